// File: rtl/move_check_sequencer_if.sv
// Request, checker-bank and response channels of the move check sequencer.
// The sequencer uses the slave modport; the game-play side and checker bank use master.
interface move_check_sequencer_if;
  // Move request from the game-play FSM
  logic                 req_valid;
  logic                 req_ready;
  logic [2:0]           old_x;
  logic [2:0]           old_y;
  logic [2:0]           new_x;
  logic [2:0]           new_y;
  logic                 side;
  logic [7:0][7:0][3:0] board_in;  // [y][x]; bit3 colour, [2:0] piece code

  // Dispatch to the per-piece checker bank
  logic                 chk_start;
  logic [2:0]           chk_sel;
  logic [2:0]           h_delta;
  logic [2:0]           v_delta;
  logic                 chk_done;
  logic                 chk_valid;

  // Verdict back to the game-play FSM
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_legal;
  logic [2:0]           rsp_code;

  modport slave (
    input  req_valid, old_x, old_y, new_x, new_y, side, board_in,
    input  chk_done, chk_valid, rsp_ready,
    output req_ready, chk_start, chk_sel, h_delta, v_delta,
    output rsp_valid, rsp_legal, rsp_code
  );

  modport master (
    output req_valid, old_x, old_y, new_x, new_y, side, board_in,
    output chk_done, chk_valid, rsp_ready,
    input  req_ready, chk_start, chk_sel, h_delta, v_delta,
    input  rsp_valid, rsp_legal, rsp_code
  );
endinterface

// File: rtl/move_check_sequencer.sv
// Validates one proposed chess move: trivial rejects locally, piece geometry via the
// checker bank, and a square-by-square path walk for sliding pieces.
module move_check_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic                   clk,
  input logic                   reset_n,
  move_check_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRECHECK,
    S_DISPATCH,
    S_WAIT,
    S_WALK,
    S_RESP
  } state_e;

  typedef enum logic [2:0] {
    RC_OK      = 3'd0,
    RC_NULL    = 3'd1,
    RC_BAD_SRC = 3'd2,
    RC_OWN_TGT = 3'd3,
    RC_GEOM    = 3'd4,
    RC_TIMEOUT = 3'd5,
    RC_BLOCKED = 3'd6
  } rsp_code_e;

  localparam logic [2:0] PC_EMPTY  = 3'd0;
  localparam logic [2:0] PC_PAWN   = 3'd1;
  localparam logic [2:0] PC_BISHOP = 3'd3;
  localparam logic [2:0] PC_ROOK   = 3'd4;
  localparam logic [2:0] PC_QUEEN  = 3'd5;
  localparam logic [2:0] PC_KING   = 3'd6;

  // Last WAIT count value; the response leaves WAIT after exactly TIMEOUT_CYCLES cycles.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  // Control and output registers
  state_e    state_q, state_d;
  logic      req_ready_q, req_ready_d;
  logic      chk_start_q, chk_start_d;
  logic [2:0] chk_sel_q, chk_sel_d;
  logic [2:0] h_delta_q, h_delta_d;
  logic [2:0] v_delta_q, v_delta_d;
  logic      rsp_valid_q, rsp_valid_d;
  logic      rsp_legal_q, rsp_legal_d;
  rsp_code_e rsp_code_q, rsp_code_d;

  // Latched request
  logic [2:0] ox_q, ox_d;
  logic [2:0] oy_q, oy_d;
  logic [2:0] nx_q, nx_d;
  logic [2:0] ny_q, ny_d;
  logic       side_q, side_d;
  logic [3:0] piece_q, piece_d;
  logic [3:0] tgt_q, tgt_d;

  // WAIT timer and path-walk cursor
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] cx_q, cx_d;
  logic [2:0] cy_q, cy_d;
  logic [2:0] sx_q, sx_d;
  logic [2:0] sy_q, sy_d;

  // Response taken this cycle, shared by every state that can end a request
  logic      fin;
  logic      fin_legal;
  rsp_code_e fin_code;

  logic [2:0] h_abs, v_abs;
  logic [2:0] step_x, step_y;
  logic       is_null, bad_src, own_tgt;
  logic       is_slider, is_line;
  logic [3:0] cursor_sq;

  // Step is a 3-bit two's-complement value so cursor += step wraps like a signed add.
  function automatic logic [2:0] step_of(input logic [2:0] from, input logic [2:0] to);
    if (to > from)      return 3'd1;
    else if (to < from) return 3'b111;
    else                return 3'd0;
  endfunction

  assign h_abs  = (nx_q >= ox_q) ? (nx_q - ox_q) : (ox_q - nx_q);
  assign v_abs  = (ny_q >= oy_q) ? (ny_q - oy_q) : (oy_q - ny_q);
  assign step_x = step_of(ox_q, nx_q);
  assign step_y = step_of(oy_q, ny_q);

  assign is_null = (ox_q == nx_q) && (oy_q == ny_q);
  assign bad_src = (piece_q[2:0] == PC_EMPTY) || (piece_q[2:0] > PC_KING) ||
                   (piece_q[3] != side_q);
  assign own_tgt = (tgt_q[2:0] != PC_EMPTY) && (tgt_q[3] == side_q);

  // A pawn double push is the only non-slider move with an intermediate square.
  assign is_slider = (piece_q[2:0] inside {PC_BISHOP, PC_ROOK, PC_QUEEN}) ||
                     ((piece_q[2:0] == PC_PAWN) && (v_delta_q == 3'd2));
  assign is_line   = (h_delta_q == 3'd0) || (v_delta_q == 3'd0) || (h_delta_q == v_delta_q);
  assign cursor_sq = bus.board_in[cy_q][cx_q];

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned
    // (which would infer a latch).
    state_d     = state_q;
    req_ready_d = req_ready_q;
    chk_start_d = 1'b0;
    chk_sel_d   = chk_sel_q;
    h_delta_d   = h_delta_q;
    v_delta_d   = v_delta_q;
    rsp_valid_d = rsp_valid_q;
    rsp_legal_d = rsp_legal_q;
    rsp_code_d  = rsp_code_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    nx_d        = nx_q;
    ny_d        = ny_q;
    side_d      = side_q;
    piece_d     = piece_q;
    tgt_d       = tgt_q;
    cnt_d       = cnt_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    fin         = 1'b0;
    fin_legal   = 1'b0;
    fin_code    = RC_OK;

    unique case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (bus.req_valid && req_ready_q) begin
          ox_d        = bus.old_x;
          oy_d        = bus.old_y;
          nx_d        = bus.new_x;
          ny_d        = bus.new_y;
          side_d      = bus.side;
          piece_d     = bus.board_in[bus.old_y][bus.old_x];
          tgt_d       = bus.board_in[bus.new_y][bus.new_x];
          req_ready_d = 1'b0;
          state_d     = S_PRECHECK;
        end
      end

      S_PRECHECK: begin
        if (is_null) begin
          fin      = 1'b1;
          fin_code = RC_NULL;
        end else if (bad_src) begin
          fin      = 1'b1;
          fin_code = RC_BAD_SRC;
        end else if (own_tgt) begin
          fin      = 1'b1;
          fin_code = RC_OWN_TGT;
        end else begin
          chk_start_d = 1'b1;
          chk_sel_d   = piece_q[2:0];
          h_delta_d   = h_abs;
          v_delta_d   = v_abs;
          state_d     = S_DISPATCH;
        end
      end

      S_DISPATCH: begin
        cnt_d   = 8'd0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // A checker verdict landing on the timeout cycle takes priority.
        if (bus.chk_done) begin
          if (!bus.chk_valid || (is_slider && !is_line)) begin
            fin      = 1'b1;
            fin_code = RC_GEOM;
          end else if (is_slider) begin
            sx_d    = step_x;
            sy_d    = step_y;
            cx_d    = ox_q + step_x;
            cy_d    = oy_q + step_y;
            state_d = S_WALK;
          end else begin
            fin       = 1'b1;
            fin_legal = 1'b1;
          end
        end else if (cnt_q == WAIT_LAST) begin
          fin      = 1'b1;
          fin_code = RC_TIMEOUT;
        end
      end

      S_WALK: begin
        if ((cx_q == nx_q) && (cy_q == ny_q)) begin
          fin       = 1'b1;
          fin_legal = 1'b1;
        end else if (cursor_sq[2:0] != PC_EMPTY) begin
          fin      = 1'b1;
          fin_code = RC_BLOCKED;
        end else begin
          cx_d = cx_q + sx_q;
          cy_d = cy_q + sy_q;
        end
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (fin) begin
      rsp_valid_d = 1'b1;
      rsp_legal_d = fin_legal;
      rsp_code_d  = fin_code;
      state_d     = S_RESP;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      chk_start_q <= 1'b0;
      chk_sel_q   <= 3'd0;
      h_delta_q   <= 3'd0;
      v_delta_q   <= 3'd0;
      rsp_valid_q <= 1'b0;
      rsp_legal_q <= 1'b0;
      rsp_code_q  <= RC_OK;
      ox_q        <= 3'd0;
      oy_q        <= 3'd0;
      nx_q        <= 3'd0;
      ny_q        <= 3'd0;
      side_q      <= 1'b0;
      piece_q     <= 4'd0;
      tgt_q       <= 4'd0;
      cnt_q       <= 8'd0;
      cx_q        <= 3'd0;
      cy_q        <= 3'd0;
      sx_q        <= 3'd0;
      sy_q        <= 3'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      chk_start_q <= chk_start_d;
      chk_sel_q   <= chk_sel_d;
      h_delta_q   <= h_delta_d;
      v_delta_q   <= v_delta_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_legal_q <= rsp_legal_d;
      rsp_code_q  <= rsp_code_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      nx_q        <= nx_d;
      ny_q        <= ny_d;
      side_q      <= side_d;
      piece_q     <= piece_d;
      tgt_q       <= tgt_d;
      cnt_q       <= cnt_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.chk_start = chk_start_q;
  assign bus.chk_sel   = chk_sel_q;
  assign bus.h_delta   = h_delta_q;
  assign bus.v_delta   = v_delta_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_legal = rsp_legal_q;
  assign bus.rsp_code  = rsp_code_q;

endmodule
